// File: rtl/alu_result_stage.sv
// Registered result stage behind the ALU: captures result, destination tag and flags.
// Define ALU_RESULT_SKID_EN for a 2-entry skid FIFO with a registered in_ready.
module alu_result_stage #(
    parameter int         DEST_W    = 4,
    parameter logic [2:0] FLAGS_RST = 3'b000
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [31:0]       c,
    input  logic              carry_out,
    input  logic              is_zero,
    input  logic              is_negative,
    input  logic [DEST_W-1:0] dest,
    input  logic              set_flags,
    input  logic              flags_we,
    input  logic [2:0]        flags_wdata,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [31:0]       out_data,
    output logic [DEST_W-1:0] out_dest,
    output logic              flag_c,
    output logic              flag_z,
    output logic              flag_n,
    output logic [1:0]        occupancy
);

    logic              accept;
    logic [2:0]        flags_q;
    logic [31:0]       data_q;
    logic [DEST_W-1:0] dest_q;

    assign accept                   = in_valid & in_ready;
    assign {flag_c, flag_z, flag_n} = flags_q;
    assign out_data                 = data_q;
    assign out_dest                 = dest_q;

    // Flags move at accept time so a following adc/sbc sees the new carry
    // even while the producing result is still stalled downstream.
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of block ordering.
    always_ff @(posedge clk) begin
        if (reset)
            flags_q <= FLAGS_RST;
        else if (accept && set_flags)
            flags_q <= {carry_out, is_zero, is_negative};
        else if (flags_we)
            flags_q <= flags_wdata;
    end

`ifdef ALU_RESULT_SKID_EN
    logic [1:0]        count_q;
    logic [1:0]        count_next;
    logic              ready_q;
    logic              pop;
    logic [31:0]       skid_data_q;
    logic [DEST_W-1:0] skid_dest_q;

    assign out_valid = (count_q != 2'd0);
    assign pop       = out_valid & out_ready;
    assign in_ready  = ready_q;
    assign occupancy = count_q;

    // NOTE: default assignment first keeps this block free of inferred latches.
    always_comb begin
        count_next = count_q;
        case ({accept, pop})
            2'b10:   count_next = count_q + 2'd1;
            2'b01:   count_next = count_q - 2'd1;
            default: count_next = count_q;
        endcase
    end

    // Head (data_q/dest_q) is always the oldest entry; skid holds the second.
    always_ff @(posedge clk) begin
        if (reset) begin
            count_q     <= 2'd0;
            ready_q     <= 1'b1;
            data_q      <= '0;
            dest_q      <= '0;
            skid_data_q <= '0;
            skid_dest_q <= '0;
        end else begin
            count_q <= count_next;
            ready_q <= (count_next != 2'd2);
            if (pop && count_q == 2'd2) begin
                data_q <= skid_data_q;
                dest_q <= skid_dest_q;
            end else if (accept && (count_q == 2'd0 || pop)) begin
                data_q <= c;
                dest_q <= dest;
            end
            if (accept && count_q == 2'd1 && !pop) begin
                skid_data_q <= c;
                skid_dest_q <= dest;
            end
        end
    end
`else
    logic valid_q;

    assign out_valid = valid_q;
    assign in_ready  = !valid_q | out_ready;
    assign occupancy = {1'b0, valid_q};

    always_ff @(posedge clk) begin
        if (reset) begin
            valid_q <= 1'b0;
            data_q  <= '0;
            dest_q  <= '0;
        end else if (accept) begin
            valid_q <= 1'b1;
            data_q  <= c;
            dest_q  <= dest;
        end else if (out_ready) begin
            valid_q <= 1'b0;
        end
    end
`endif

endmodule

// File: tb/tb_alu_result_stage.sv
// Directed self-checking bench for alu_result_stage (single-entry or skid build).
module tb_alu_result_stage;

    localparam int DEST_W = 4;

    logic              clk = 1'b0;
    logic              reset;
    logic              in_valid;
    logic              in_ready;
    logic [31:0]       c;
    logic              carry_out;
    logic              is_zero;
    logic              is_negative;
    logic [DEST_W-1:0] dest;
    logic              set_flags;
    logic              flags_we;
    logic [2:0]        flags_wdata;
    logic              out_valid;
    logic              out_ready;
    logic [31:0]       out_data;
    logic [DEST_W-1:0] out_dest;
    logic              flag_c;
    logic              flag_z;
    logic              flag_n;
    logic [1:0]        occupancy;

    int tests  = 0;
    int failed = 0;

    alu_result_stage #(.DEST_W(DEST_W), .FLAGS_RST(3'b000)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .c(c), .carry_out(carry_out), .is_zero(is_zero), .is_negative(is_negative),
        .dest(dest), .set_flags(set_flags), .flags_we(flags_we), .flags_wdata(flags_wdata),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_dest(out_dest), .flag_c(flag_c), .flag_z(flag_z), .flag_n(flag_n),
        .occupancy(occupancy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            failed++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [31:0] d, input logic [3:0] t,
                         input logic sf, input logic [2:0] f);
        in_valid = v;
        c        = d;
        dest     = t;
        set_flags = sf;
        {carry_out, is_zero, is_negative} = f;
    endtask

    initial begin
        reset = 1'b1; out_ready = 1'b1; flags_we = 1'b0; flags_wdata = 3'b000;
        drive(1'b0, 32'h0, 4'h0, 1'b0, 3'b000);

        // 1: reset held two cycles
        step(); step();
        check("rst_out_valid", {31'b0, out_valid}, 32'd0);
        check("rst_flags", {29'b0, flag_c, flag_z, flag_n}, 32'd0);
        check("rst_occupancy", {30'b0, occupancy}, 32'd0);
        check("rst_in_ready", {31'b0, in_ready}, 32'd1);
        reset = 1'b0;

        // 2: one-cycle latency, flags loaded on accept
        drive(1'b1, 32'h0, 4'd3, 1'b1, 3'b110);
        step();
        drive(1'b0, 32'h0, 4'd0, 1'b0, 3'b000);
        check("t2_out_valid", {31'b0, out_valid}, 32'd1);
        check("t2_out_data", out_data, 32'h0);
        check("t2_out_dest", {28'b0, out_dest}, 32'd3);
        check("t2_flags", {29'b0, flag_c, flag_z, flag_n}, 32'b110);
        step();
        check("t2_drained", {31'b0, out_valid}, 32'd0);

        // 3: backpressure
        out_ready = 1'b0;
        drive(1'b1, 32'h11, 4'd1, 1'b0, 3'b000);
        step();
        check("t3_head", out_data, 32'h11);
        drive(1'b1, 32'h22, 4'd2, 1'b1, 3'b001);
        #1;
`ifdef ALU_RESULT_SKID_EN
        check("t3_in_ready_2nd", {31'b0, in_ready}, 32'd1);
`else
        check("t3_in_ready_2nd", {31'b0, in_ready}, 32'd0);
`endif
        step();
        drive(1'b0, 32'h0, 4'd0, 1'b0, 3'b000);
        check("t3_head_stable", out_data, 32'h11);
        check("t3_dest_stable", {28'b0, out_dest}, 32'd1);
`ifdef ALU_RESULT_SKID_EN
        check("t3_flags", {29'b0, flag_c, flag_z, flag_n}, 32'b001);
        check("t3_occupancy", {30'b0, occupancy}, 32'd2);
        check("t3_in_ready_full", {31'b0, in_ready}, 32'd0);
`else
        check("t3_flags", {29'b0, flag_c, flag_z, flag_n}, 32'b110);
        check("t3_occupancy", {30'b0, occupancy}, 32'd1);
`endif
        step();
        check("t3_still_stable", out_data, 32'h11);
        out_ready = 1'b1;
        step();
`ifdef ALU_RESULT_SKID_EN
        check("t3_second_valid", {31'b0, out_valid}, 32'd1);
        check("t3_second_data", out_data, 32'h22);
        check("t3_second_dest", {28'b0, out_dest}, 32'd2);
        step();
`endif
        check("t3_empty", {31'b0, out_valid}, 32'd0);

        // 4: ALU flag update beats direct write in the same cycle
        flags_we = 1'b1; flags_wdata = 3'b001;
        drive(1'b1, 32'h5, 4'd5, 1'b1, 3'b100);
        step();
        drive(1'b0, 32'h0, 4'd0, 1'b0, 3'b000);
        check("t4_alu_wins", {29'b0, flag_c, flag_z, flag_n}, 32'b100);
        check("t4_data", out_data, 32'h5);
        step();
        flags_we = 1'b0;
        check("t4_direct_write", {29'b0, flag_c, flag_z, flag_n}, 32'b001);
        check("t4_drained", {31'b0, out_valid}, 32'd0);

        // 5: negative result without set_flags, then set_flags without valid
        drive(1'b1, 32'h8000_0000, 4'd7, 1'b0, 3'b001);
        step();
        drive(1'b0, 32'h0, 4'd0, 1'b1, 3'b111);
        check("t5_data", out_data, 32'h8000_0000);
        check("t5_dest", {28'b0, out_dest}, 32'd7);
        check("t5_flags_hold", {29'b0, flag_c, flag_z, flag_n}, 32'b001);
        step();
        check("t5_no_valid_flags", {29'b0, flag_c, flag_z, flag_n}, 32'b001);
        drive(1'b0, 32'h0, 4'd0, 1'b0, 3'b000);

        // pop and push on the same edge while full
        drive(1'b1, 32'hA, 4'd10, 1'b0, 3'b000);
        step();
        drive(1'b1, 32'hB, 4'd11, 1'b0, 3'b000);
        step();
        drive(1'b0, 32'h0, 4'd0, 1'b0, 3'b000);
        check("pp_valid", {31'b0, out_valid}, 32'd1);
        check("pp_data", out_data, 32'hB);
        check("pp_occupancy", {30'b0, occupancy}, 32'd1);
        step();

        // 6: reset while full drops entries and ignores the concurrent beat
        out_ready = 1'b0;
        drive(1'b1, 32'h33, 4'd4, 1'b1, 3'b111);
        step();
        check("t6_full_flags", {29'b0, flag_c, flag_z, flag_n}, 32'b111);
        reset = 1'b1;
        drive(1'b1, 32'h44, 4'd6, 1'b1, 3'b010);
        step();
        reset = 1'b0;
        drive(1'b0, 32'h0, 4'd0, 1'b0, 3'b000);
        check("t6_out_valid", {31'b0, out_valid}, 32'd0);
        check("t6_occupancy", {30'b0, occupancy}, 32'd0);
        check("t6_flags", {29'b0, flag_c, flag_z, flag_n}, 32'b000);
        check("t6_out_data", out_data, 32'h0);
        step();
        check("t6_stays_empty", {31'b0, out_valid}, 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
